avalon_ws_mem: RTL

AVALON_WS_MEM -- requirements
Module: avalon_ws_mem

---
 rtl/avmem_pkg.sv | 21 ++
 rtl/avmem_lfsr.sv | 29 ++
 rtl/avalon_ws_mem.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/avmem_pkg.sv
// Shared definitions for the Avalon wait-state memory slave.
//   state_t         : transfer FSM states (IDLE, WAIT, ACK)
//   MAX_WAIT_CYCLES : largest legal WAIT_CYCLES value
//   CNT_W           : wait counter width (covers MAX_WAIT_CYCLES plus random extra 0..3)
//   LFSR_SEED/TAPS  : 16-bit Fibonacci LFSR seed and tap mask (taps 16,14,13,11)
package avmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int MAX_WAIT_CYCLES = 15;
  localparam int CNT_W = $clog2(MAX_WAIT_CYCLES + 3 + 1);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Bit k-1 set for tap k: taps 16,14,13,11 -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/avmem_lfsr.sv
// 16-bit Fibonacci LFSR supplying 0..3 extra wait cycles per transfer.
// Only instantiated when AVMEM_RANDOM_WAIT_EN is defined.
// Ports:
//   clk        : clock
//   reset_n    : synchronous active-low reset, reloads LFSR_SEED
//   advance    : step the sequence once (asserted during each ACK cycle)
//   wait_extra : low two bits of the current LFSR state
module avmem_lfsr
  import avmem_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  output logic [1:0] wait_extra
);

  logic [15:0] lfsr_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_reg <= LFSR_SEED;
    end else if (advance) begin
      lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
    end
  end

  assign wait_extra = lfsr_reg[1:0];

endmodule

// File: rtl/avalon_ws_mem.sv
// Avalon-MM slave memory with a fixed (or optionally randomised) number of
// waitrequest cycles per transfer, a side-band preload port and a sticky
// error flag.
// Build option: define AVMEM_RANDOM_WAIT_EN to add 0..3 LFSR-chosen wait
// cycles to every transfer (default build: exactly WAIT_CYCLES).
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   address/read/write    : Avalon request (byte address)
//   writedata/byteenable  : write data and byte lanes
//   waitrequest           : stall to master
//   readdata              : read data, non-zero only in the ACK cycle of a read
//   load_en/addr/data     : preload port, works in any state and during reset
//   err                   : sticky range / alignment / protocol error
module avalon_ws_mem
  import avmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  output logic        err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] n_cycles;
  logic [IDX_W-1:0] idx_reg;
  logic             in_range_reg;
  logic             is_read_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       be_reg;
  logic             err_reg;
  logic [31:0]      readdata_reg;

  logic             req;
  logic [31:0]      offset;
  logic             addr_in_range;
  logic [IDX_W-1:0] addr_idx;
  logic             in_idle;
  logic [IDX_W-1:0] xfer_idx;
  logic             xfer_rd;
  logic             xfer_in_range;
  logic             load_in_range;
  logic [IDX_W-1:0] load_idx;
  logic             unused_load_lsbs;

  assign req           = read | write;
  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign offset        = address - BASE_ADDR;
  assign addr_in_range = offset < 32'(4 * DEPTH_WORDS);
  assign addr_idx      = offset[IDX_W+1:2];

  // With N = 1 the transfer goes IDLE -> ACK directly, so the read for the
  // ACK cycle must come from the live bus rather than the latched copy.
  assign in_idle       = (state_reg == IDLE);
  assign xfer_idx      = in_idle ? addr_idx      : idx_reg;
  assign xfer_rd       = in_idle ? read          : is_read_reg;
  assign xfer_in_range = in_idle ? addr_in_range : in_range_reg;

  assign load_in_range    = {26'd0, load_addr[7:2]} < 32'(DEPTH_WORDS);
  assign load_idx         = IDX_W'(load_addr[7:2]);
  assign unused_load_lsbs = ^load_addr[1:0];

`ifdef AVMEM_RANDOM_WAIT_EN
  logic [1:0] wait_extra;

  avmem_lfsr u_lfsr (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (state_reg == ACK),
    .wait_extra (wait_extra)
  );

  assign n_cycles = CNT_W'(WAIT_CYCLES) + CNT_W'(wait_extra);
`else
  assign n_cycles = CNT_W'(WAIT_CYCLES);
`endif

  // cnt_reg holds the number of WAIT cycles still to go after the current
  // one; the IDLE request cycle already counts as the first stall cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    waitrequest = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          waitrequest = 1'b1;
          if (n_cycles <= CNT_W'(1)) begin
            state_next = ACK;
          end else begin
            state_next = WAIT;
            cnt_next   = n_cycles - CNT_W'(2);
          end
        end
      end
      WAIT: begin
        waitrequest = 1'b1;
        if (!req) begin
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACK: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (!reset_n) begin
      waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      readdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      readdata_reg <= '0;
      if (in_idle && req) begin
        idx_reg      <= addr_idx;
        in_range_reg <= addr_in_range;
        is_read_reg  <= read;   // read wins when both are asserted
        wdata_reg    <= writedata;
        be_reg       <= byteenable;
        if (!addr_in_range || (address[1:0] != 2'b00) || (read && write)) begin
          err_reg <= 1'b1;
        end
      end
      if ((state_reg == WAIT) && !req) begin
        err_reg <= 1'b1;
      end
      if ((state_next == ACK) && xfer_rd && xfer_in_range) begin
        readdata_reg <= mem[xfer_idx];
      end
    end
  end

  // Memory contents are never reset. The bus write is issued after the
  // preload so that, on a same-word collision, its enabled lanes win.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
    if (reset_n && (state_reg == ACK) && !is_read_reg && in_range_reg) begin
      for (int i = 0; i < 4; i++) begin
        if (be_reg[i]) begin
          mem[idx_reg][8*i +: 8] <= wdata_reg[8*i +: 8];
        end
      end
    end
  end

  assign readdata = readdata_reg;
  assign err      = err_reg;

endmodule
